cfg_reader: RTL and testbench

- Read-only, memory-mapped configuration discovery responder.
- Software or the debug module issues burst reads and gets back the elaborated `config_pkg::cva6_cfg_t` fields as 32-bit words: ISA feature bitmap, sizes, and the execute/cached/non-idempotent region tables.
- It is the runtime read side of the static core configuration. It sits on the peripheral side of the CLINT/debug interconnect.

---
 rtl/cfg_reader_pkg.sv | 79 +++++++
 rtl/config_pkg.sv | 33 +++
 rtl/cfg_reader_rom.sv | 47 ++++
 rtl/cfg_reader.sv | 99 +++++++++
 tb/tb_cfg_reader.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/cfg_reader_pkg.sv
// Word map, feature bit positions and FSM state for the configuration reader.
package cfg_reader_pkg;

  localparam logic [31:0] MAGIC = 32'hC0F6_0001;

  localparam logic [31:0] WORD_MAGIC   = 32'h00;
  localparam logic [31:0] WORD_XLEN    = 32'h01;
  localparam logic [31:0] FEAT         = 32'h02;
  localparam logic [31:0] WORD_PMP     = 32'h03;
  localparam logic [31:0] WORD_SB      = 32'h04;
  localparam logic [31:0] WORD_ICACHE  = 32'h05;
  localparam logic [31:0] WORD_DCACHE  = 32'h06;
  localparam logic [31:0] WORD_GEOM    = 32'h07;
  localparam logic [31:0] EXEC_BASE    = 32'h10;
  localparam logic [31:0] CACHED_BASE  = 32'h50;
  localparam logic [31:0] NONIDEM_BASE = 32'h90;
  localparam logic [31:0] MAP_END      = 32'hD0;

  localparam int unsigned FEAT_RVA      = 0;
  localparam int unsigned FEAT_RVB      = 1;
  localparam int unsigned FEAT_RVC      = 2;
  localparam int unsigned FEAT_RVH      = 3;
  localparam int unsigned FEAT_RVV      = 4;
  localparam int unsigned FEAT_FPU      = 5;
  localparam int unsigned FEAT_MMU      = 6;
  localparam int unsigned FEAT_DEBUG    = 7;
  localparam int unsigned FEAT_CVXIF    = 8;
  localparam int unsigned FEAT_RVZCB    = 9;
  localparam int unsigned FEAT_RVZCMP   = 10;
  localparam int unsigned FEAT_RVZICOND = 11;
  localparam int unsigned FEAT_PERF     = 12;
  localparam int unsigned FEAT_RVS      = 13;
  localparam int unsigned FEAT_RVU      = 14;

  typedef enum logic {ST_IDLE, ST_STREAM} cfg_rd_state_e;

  function automatic logic [31:0] feat_word(input config_pkg::cva6_cfg_t c);
    logic [31:0] f;
    f = '0;
    f[FEAT_RVA]      = c.RVA;
    f[FEAT_RVB]      = c.RVB;
    f[FEAT_RVC]      = c.RVC;
    f[FEAT_RVH]      = c.RVH;
    f[FEAT_RVV]      = c.RVV;
    f[FEAT_FPU]      = c.FpuEn;
    f[FEAT_MMU]      = c.MmuPresent;
    f[FEAT_DEBUG]    = c.DebugEn;
    f[FEAT_CVXIF]    = c.CvxifEn;
    f[FEAT_RVZCB]    = c.RVZCB;
    f[FEAT_RVZCMP]   = c.RVZCMP;
    f[FEAT_RVZICOND] = c.RVZiCond;
    f[FEAT_PERF]     = c.PerfCounterEn;
    f[FEAT_RVS]      = c.RVS;
    f[FEAT_RVU]      = c.RVU;
    return f;
  endfunction

  // off = word offset inside a 64-word table: rule = off/4, word = off%4
  function automatic logic [31:0] rule_word(
    input logic [config_pkg::NrMaxRules*64-1:0] base,
    input logic [config_pkg::NrMaxRules*64-1:0] len,
    input int unsigned nr,
    input logic [5:0] off
  );
    int unsigned r;
    logic [63:0] b, l;
    r = 32'(off[5:2]);
    if (r >= nr) return '0;
    b = base[r*64 +: 64];
    l = len[r*64 +: 64];
    case (off[1:0])
      2'd0:    return b[31:0];
      2'd1:    return b[63:32];
      2'd2:    return l[31:0];
      default: return l[63:32];
    endcase
  endfunction

endpackage

// File: rtl/config_pkg.sv
// Elaborated core configuration subset served by the configuration reader.
// Region tables hold up to NrMaxRules 64-bit entries, rule r at bits [64r +: 64].
package config_pkg;

  localparam int unsigned NrMaxRules = 16;

  typedef struct packed {
    int unsigned XLEN;
    logic RVA, RVB, RVC, RVH, RVV;
    logic FpuEn, MmuPresent, DebugEn, CvxifEn;
    logic RVZCB, RVZCMP, RVZiCond, PerfCounterEn, RVS, RVU;
    int unsigned NrPMPEntries;
    int unsigned NrScoreboardEntries;
    int unsigned IcacheByteSize;
    int unsigned DcacheByteSize;
    int unsigned IcacheSetAssoc;
    int unsigned DcacheSetAssoc;
    int unsigned NrCommitPorts;
    logic [1:0]  DCacheType;
    int unsigned NrExecuteRegionRules;
    logic [NrMaxRules*64-1:0] ExecuteRegionAddrBase;
    logic [NrMaxRules*64-1:0] ExecuteRegionLength;
    int unsigned NrCachedRegionRules;
    logic [NrMaxRules*64-1:0] CachedRegionAddrBase;
    logic [NrMaxRules*64-1:0] CachedRegionLength;
    int unsigned NrNonIdempotentRules;
    logic [NrMaxRules*64-1:0] NonIdempotentAddrBase;
    logic [NrMaxRules*64-1:0] NonIdempotentLength;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// File: rtl/cfg_reader_rom.sv
// Combinational word-index to {data, err} lookup over the elaborated configuration.
// Zero latency; no flow control of its own.
module cfg_reader_rom
  import cfg_reader_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int unsigned IdxWidth = 10
) (
  input  logic [IdxWidth-1:0] idx_i,
  output logic [31:0]         data_o,
  output logic                err_o
);

  logic [31:0] w;
  assign w = 32'(idx_i);

  always_comb begin
    data_o = '0;
    err_o  = 1'b0;
    if (w >= MAP_END) begin
      err_o = 1'b1;
    end else if (w >= NONIDEM_BASE) begin
      data_o = rule_word(CVA6Cfg.NonIdempotentAddrBase, CVA6Cfg.NonIdempotentLength,
                         CVA6Cfg.NrNonIdempotentRules, 6'(w - NONIDEM_BASE));
    end else if (w >= CACHED_BASE) begin
      data_o = rule_word(CVA6Cfg.CachedRegionAddrBase, CVA6Cfg.CachedRegionLength,
                         CVA6Cfg.NrCachedRegionRules, 6'(w - CACHED_BASE));
    end else if (w >= EXEC_BASE) begin
      data_o = rule_word(CVA6Cfg.ExecuteRegionAddrBase, CVA6Cfg.ExecuteRegionLength,
                         CVA6Cfg.NrExecuteRegionRules, 6'(w - EXEC_BASE));
    end else begin
      case (w)
        WORD_MAGIC:  data_o = MAGIC;
        WORD_XLEN:   data_o = CVA6Cfg.XLEN;
        FEAT:        data_o = feat_word(CVA6Cfg);
        WORD_PMP:    data_o = CVA6Cfg.NrPMPEntries;
        WORD_SB:     data_o = CVA6Cfg.NrScoreboardEntries;
        WORD_ICACHE: data_o = CVA6Cfg.IcacheByteSize;
        WORD_DCACHE: data_o = CVA6Cfg.DcacheByteSize;
        WORD_GEOM:   data_o = {CVA6Cfg.IcacheSetAssoc[7:0], CVA6Cfg.DcacheSetAssoc[7:0],
                               CVA6Cfg.NrCommitPorts[7:0], 6'b0, CVA6Cfg.DCacheType};
        default:     data_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/cfg_reader.sv
// Burst-read responder for the static core configuration; first beat 1 cycle after request.
// Response beats hold stable under rsp_ready_i low; no new request until the burst drains.
module cfg_reader
  import cfg_reader_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int unsigned AddrWidth = 12,
  parameter int unsigned LenWidth  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [LenWidth-1:0]  req_len_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_data_o,
  output logic                 rsp_err_o,
  output logic                 rsp_last_o,
  output logic                 busy_o
);

  localparam int unsigned IW = AddrWidth - 2;

  cfg_rd_state_e       state;
  logic [IW-1:0]       idx_q, idx_nxt;
  logic [LenWidth-1:0] rem_q;
  logic                mis_q, mis_cur;
  logic                req_hs, beat_hs;
  logic [31:0]         rom_data;
  logic                rom_err;

  assign req_hs  = req_valid_i & req_ready_o;
  assign beat_hs = rsp_valid_o & rsp_ready_i;
  assign mis_cur = req_hs ? (req_addr_i[1:0] != 2'b00) : mis_q;

  // Look up the word for the beat presented next, so outputs can be registered.
  always_comb begin
    idx_nxt = idx_q;
    if (req_hs)                        idx_nxt = req_addr_i[AddrWidth-1:2];
    else if (beat_hs && rem_q != '0)   idx_nxt = idx_q + 1'b1;
  end

  cfg_reader_rom #(.CVA6Cfg(CVA6Cfg), .IdxWidth(IW)) u_rom (
    .idx_i  (idx_nxt),
    .data_o (rom_data),
    .err_o  (rom_err)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
      rsp_last_o  <= 1'b0;
      idx_q       <= '0;
      rem_q       <= '0;
      mis_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (req_hs) begin
          state       <= ST_STREAM;
          req_ready_o <= 1'b0;
          rsp_valid_o <= 1'b1;
          busy_o      <= 1'b1;
          idx_q       <= idx_nxt;
          rem_q       <= req_len_i;
          mis_q       <= mis_cur;
          rsp_data_o  <= mis_cur ? '0 : rom_data;
          rsp_err_o   <= mis_cur | rom_err;
          rsp_last_o  <= (req_len_i == '0);
        end
        ST_STREAM: if (beat_hs) begin
          if (rem_q == '0) begin
            state       <= ST_IDLE;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b0;
            rsp_last_o  <= 1'b0;
          end else begin
            idx_q      <= idx_nxt;
            rem_q      <= rem_q - 1'b1;
            rsp_data_o <= mis_cur ? '0 : rom_data;
            rsp_err_o  <= mis_cur | rom_err;
            rsp_last_o <= (rem_q == LenWidth'(1));
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_reader.sv
// Directed bench for cfg_reader using a cv32a6_imac_sv32-style configuration.
module tb_cfg_reader;

  function automatic config_pkg::cva6_cfg_t build_cfg();
    config_pkg::cva6_cfg_t c;
    c = '0;
    c.XLEN = 32;
    c.RVA = 1'b1; c.RVC = 1'b1; c.MmuPresent = 1'b1; c.DebugEn = 1'b1;
    c.PerfCounterEn = 1'b1; c.RVS = 1'b1; c.RVU = 1'b1;
    c.NrPMPEntries = 8;
    c.NrScoreboardEntries = 8;
    c.IcacheByteSize = 16384;
    c.DcacheByteSize = 32768;
    c.IcacheSetAssoc = 4;
    c.DcacheSetAssoc = 8;
    c.NrCommitPorts = 2;
    c.DCacheType = 2'd1;
    c.NrExecuteRegionRules = 3;
    c.ExecuteRegionAddrBase[0*64 +: 64] = 64'h0;
    c.ExecuteRegionLength[0*64 +: 64]   = 64'h1000;
    c.ExecuteRegionAddrBase[1*64 +: 64] = 64'h1_0000;
    c.ExecuteRegionLength[1*64 +: 64]   = 64'h1_0000;
    c.ExecuteRegionAddrBase[2*64 +: 64] = 64'h8000_0000;
    c.ExecuteRegionLength[2*64 +: 64]   = 64'h4000_0000;
    c.ExecuteRegionAddrBase[3*64 +: 64] = 64'hDEAD_BEEF;   // beyond Nr, must not show
    c.NrCachedRegionRules = 1;
    c.CachedRegionAddrBase[0*64 +: 64] = 64'h8000_0000;
    c.CachedRegionLength[0*64 +: 64]   = 64'h4000_0000;
    c.NrNonIdempotentRules = 2;
    c.NonIdempotentAddrBase[0*64 +: 64] = 64'h0;
    c.NonIdempotentLength[0*64 +: 64]   = 64'h8000_0000;
    c.NonIdempotentAddrBase[1*64 +: 64] = 64'hC000_0000;
    c.NonIdempotentLength[1*64 +: 64]   = 64'h4000_0000;
    c.NonIdempotentLength[15*64 +: 64]  = 64'h1234_5678;
    return c;
  endfunction

  localparam config_pkg::cva6_cfg_t TbCfg = build_cfg();

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [11:0] req_addr;
  logic [3:0]  req_len;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err, rsp_last, busy;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] ed [16];
  logic [15:0] ee;
  int          stl [16];

  cfg_reader #(.CVA6Cfg(TbCfg), .AddrWidth(12), .LenWidth(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_len_i   (req_len),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .rsp_last_o  (rsp_last),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    ee = '0;
    for (int i = 0; i < 16; i++) begin
      ed[i]  = '0;
      stl[i] = 0;
    end
  endtask

  task automatic beat_chk(input string tag, input int b, input logic last);
    chk({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".data"},  rsp_data, ed[b]);
    chk({tag, ".err"},   32'(rsp_err), 32'(ee[b]));
    chk({tag, ".last"},  32'(rsp_last), 32'(last));
  endtask

  // One full burst; ed/ee hold expected beats, stl the stall cycles before each accept.
  task automatic burst(input string name, input logic [11:0] addr, input logic [3:0] len);
    @(negedge clk);
    chk({name, ".idle_rdy"}, 32'(req_ready), 32'd1);
    chk({name, ".idle_vld"}, 32'(rsp_valid), 32'd0);
    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = len;
    @(negedge clk);
    req_valid = 1'b0;
    chk({name, ".rdy_low"}, 32'(req_ready), 32'd0);
    chk({name, ".busy"},    32'(busy), 32'd1);
    for (int b = 0; b <= int'(len); b++) begin
      for (int s = 0; s < stl[b]; s++) begin
        beat_chk($sformatf("%s.hold%0d", name, b), b, (b == int'(len)));
        @(negedge clk);
      end
      beat_chk($sformatf("%s.beat%0d", name, b), b, (b == int'(len)));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    chk({name, ".end_vld"},  32'(rsp_valid), 32'd0);
    chk({name, ".end_rdy"},  32'(req_ready), 32'd1);
    chk({name, ".end_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.req_rdy", 32'(req_ready), 32'd1);
    chk("rst.vld",     32'(rsp_valid), 32'd0);
    chk("rst.data",    rsp_data, 32'd0);
    chk("rst.err",     32'(rsp_err), 32'd0);
    chk("rst.last",    32'(rsp_last), 32'd0);
    chk("rst.busy",    32'(busy), 32'd0);
    rst = 1'b0;

    clr(); ed[0] = 32'hC0F6_0001;
    burst("magic", 12'h000, 4'd0);

    clr(); ed[0] = 32'd32; ed[1] = 32'h0000_70C5;
    burst("xlen_feat", 12'h004, 4'd1);

    clr(); ed[0] = 32'h0000_4000; ed[1] = 32'h0000_8000; ed[2] = 32'h0408_0201;
    burst("geom", 12'h014, 4'd2);

    clr(); ed[0] = 32'h8000_0000; ed[2] = 32'h4000_0000;
    stl[1] = 2; stl[3] = 1;
    burst("exec2_stall", 12'h060, 4'd3);

    clr(); ed[0] = 32'h8000_0000;
    burst("cached0", 12'h140, 4'd0);

    clr();
    burst("exec3_unused", 12'h070, 4'd0);

    clr(); ee = 16'b1100;
    burst("map_end", 12'h338, 4'd3);

    clr(); ee = 16'b0111;
    burst("misalign", 12'h002, 4'd2);

    clr(); ee = 16'b0001; ed[1] = 32'hC0F6_0001;
    burst("wrap", 12'hFFC, 4'd1);

    // Reset in the middle of an 8-beat burst.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 12'h000; req_len = 4'd7;
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst.beat3_data", rsp_data, 32'h0000_70C5);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst.vld",  32'(rsp_valid), 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.rdy",  32'(req_ready), 32'd1);
    rst = 1'b0; rsp_ready = 1'b0;

    clr(); ed[0] = 32'hC0F6_0001;
    burst("post_rst", 12'h000, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
